// File: rtl/ring_phase_monitor_if.sv
// Sample/status bundle between a one-hot ring counter consumer and the phase monitor.
// The master drives samples; the slave (the monitor) returns the registered phase status.
interface ring_phase_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             enable;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [IDX_W-1:0] phase_idx;
  logic             phase_valid;
  logic             locked;
  logic             seq_err;
  logic             wrap;
  logic [ERR_W-1:0] err_count;

  modport master (
    output enable, din, clr_err,
    input  phase_idx, phase_valid, locked, seq_err, wrap, err_count
  );

  modport slave (
    input  enable, din, clr_err,
    output phase_idx, phase_valid, locked, seq_err, wrap, err_count
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter word for legal rotate-left advances, encodes the phase,
// locks after LOCK_CNT consecutive advances and flags/counts sequence errors while locked.
module ring_phase_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input logic             clock,
  input logic             rst,
  ring_phase_monitor_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [WIDTH-1:0] w);
    return (w != {WIDTH{1'b0}}) && ((w & (w - WIDTH'(1))) == {WIDTH{1'b0}});
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], w[WIDTH-1]};
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [WIDTH-1:0] w);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i]) begin
        r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] good_q;
  logic [IDX_W-1:0] phase_idx_q;
  logic             phase_valid_q;
  logic             locked_q;
  logic             seq_err_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_q;

  logic             onehot_d;
  logic             adv_d;
  logic             stall_d;
  logic             seq_err_d;
  logic [CNT_W-1:0] good_inc_d;
  logic [ERR_W-1:0] err_d;

  // Classify the current sample against the last accepted phase and derive the error count.
  always_comb begin
    onehot_d   = is_onehot(bus.din);
    adv_d      = onehot_d && (bus.din == rotl(prev_q));
    stall_d    = (bus.din == prev_q);
    good_inc_d = good_q + CNT_W'(1);
    seq_err_d  = 1'b0;
    if (bus.enable && (state_q == ST_LOCK) && !adv_d && !stall_d) begin
      seq_err_d = 1'b1;
    end else begin
      seq_err_d = 1'b0;
    end
    err_d = err_q;
    if (bus.clr_err) begin
      err_d = {ERR_W{1'b0}};
    end else if (seq_err_d && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // Lock FSM with all status outputs registered alongside it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      prev_q        <= {WIDTH{1'b0}};
      good_q        <= {CNT_W{1'b0}};
      phase_idx_q   <= {IDX_W{1'b0}};
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      wrap_q        <= 1'b0;
      err_q         <= {ERR_W{1'b0}};
    end else begin
      seq_err_q <= seq_err_d;
      wrap_q    <= 1'b0;
      err_q     <= err_d;
      if (bus.enable) begin
        phase_valid_q <= onehot_d;
        if (onehot_d) begin
          phase_idx_q <= onehot_idx(bus.din);
        end else begin
          phase_idx_q <= phase_idx_q;
        end
        case (state_q)
          ST_IDLE: begin
            if (onehot_d) begin
              state_q <= ST_ACQ;
              prev_q  <= bus.din;
              good_q  <= {CNT_W{1'b0}};
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_ACQ: begin
            if (adv_d) begin
              prev_q <= bus.din;
              if (good_inc_d == CNT_W'(LOCK_CNT)) begin
                state_q  <= ST_LOCK;
                locked_q <= 1'b1;
                good_q   <= {CNT_W{1'b0}};
              end else begin
                good_q <= good_inc_d;
              end
            end else if (stall_d) begin
              state_q <= ST_ACQ;
            end else if (onehot_d) begin
              prev_q <= bus.din;
              good_q <= {CNT_W{1'b0}};
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_LOCK: begin
            if (adv_d) begin
              prev_q <= bus.din;
              wrap_q <= prev_q[WIDTH-1] & bus.din[0];
            end else if (stall_d) begin
              state_q <= ST_LOCK;
            end else if (onehot_d) begin
              state_q  <= ST_ACQ;
              locked_q <= 1'b0;
              prev_q   <= bus.din;
              good_q   <= {CNT_W{1'b0}};
            end else begin
              state_q  <= ST_IDLE;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign bus.phase_idx   = phase_idx_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.locked      = locked_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.wrap        = wrap_q;
  assign bus.err_count   = err_q;
endmodule
